// File: rtl/alu_seq.sv
// Sequential front-end for an external 8-bit combinational ALU: accepts op/imm,
// holds ALU inputs for SETTLE cycles, captures r/c/v. Saturation via ALU_SEQ_SAT_EN.
module alu_seq #(
  parameter int W      = 8,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_op,
  input  logic [W-1:0] in_imm,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_s,
  input  logic [W-1:0] alu_r,
  input  logic         alu_c,
  input  logic         alu_v,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] acc,
  output logic         flag_z,
  output logic         flag_c,
  output logic         flag_v,
  output logic         out_err
);

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_CLEAR = 4'b0001;
  localparam logic [3:0] OP_XFER  = 4'b1000;
  localparam logic [3:0] OP_SUB   = 4'b1001;
  localparam logic [3:0] OP_ADD   = 4'b1010;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t       state, state_nxt;
  logic [2:0]   cnt;
  logic         op_alu;
  logic [W-1:0] cap_val;

  // ALU opcodes occupy the contiguous range 0111..1110
  assign op_alu = (in_op >= 4'b0111) && (in_op != 4'b1111);

`ifdef ALU_SEQ_SAT_EN
  always_comb begin
    cap_val = alu_r;
    if (alu_c && alu_s == OP_ADD)      cap_val = '1;
    else if (alu_c && alu_s == OP_SUB) cap_val = '0;
  end
`else
  assign cap_val = alu_r;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = op_alu ? ISSUE : RESP;
      end
      ISSUE:   if (cnt == 3'd0) state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      flag_v  <= 1'b0;
      out_err <= 1'b0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_s   <= OP_XFER;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (op_alu) begin
            alu_a <= acc;
            alu_b <= in_imm;
            alu_s <= in_op;
            cnt   <= 3'(SETTLE - 1);
          end else if (in_op == OP_LOAD || in_op == OP_CLEAR) begin
            acc     <= (in_op == OP_LOAD) ? in_imm : '0;
            flag_z  <= (in_op == OP_LOAD) ? (in_imm == '0) : 1'b1;
            flag_c  <= 1'b0;
            flag_v  <= 1'b0;
            out_err <= 1'b0;
          end else begin
            // illegal opcode: state preserved, only the error bit reports
            out_err <= 1'b1;
          end
        end
        ISSUE: if (cnt != 3'd0) cnt <= cnt - 3'd1;
        CAPTURE: begin
          acc     <= cap_val;
          flag_z  <= (cap_val == '0);
          flag_c  <= alu_c;
          flag_v  <= alu_v;
          out_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: stub ALU, constant vector table, corner sequences and
// randomized traffic checked against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 8;
  localparam int SETTLE = 2;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   in_op, alu_s;
  logic [W-1:0] in_imm, alu_a, alu_b, alu_r, acc;
  logic         alu_c, alu_v, flag_z, flag_c, flag_v, out_err;

  always #5 clk = ~clk;

  alu_seq #(.W(W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_imm(in_imm), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_r(alu_r), .alu_c(alu_c), .alu_v(alu_v), .out_valid(out_valid),
    .out_ready(out_ready), .acc(acc), .flag_z(flag_z), .flag_c(flag_c),
    .flag_v(flag_v), .out_err(out_err)
  );

  // Stub of the external combinational ALU
  logic [W:0] ext;
  always_comb begin
    alu_r = '0; alu_c = 1'b0; alu_v = 1'b0; ext = '0;
    case (alu_s)
      4'b1110: alu_r = alu_a & alu_b;
      4'b1101: alu_r = alu_a | alu_b;
      4'b1100: alu_r = ~alu_a;
      4'b1011: alu_r = alu_a ^ alu_b;
      4'b1010: begin
        ext = {1'b0, alu_a} + {1'b0, alu_b};
        alu_r = ext[W-1:0]; alu_c = ext[W];
        alu_v = (alu_a[W-1] == alu_b[W-1]) && (alu_r[W-1] != alu_a[W-1]);
      end
      4'b1001: begin
        ext = {1'b0, alu_a} - {1'b0, alu_b};
        alu_r = ext[W-1:0]; alu_c = ext[W];
        alu_v = (alu_a[W-1] != alu_b[W-1]) && (alu_r[W-1] != alu_a[W-1]);
      end
      4'b1000: alu_r = alu_b;
      4'b0111: alu_r = (alu_a == '0) ? 8'd1 : 8'd0;
      default: ;
    endcase
  end

  int checks = 0, failures = 0;
  int m_acc, m_z, m_c, m_v, m_err;
  int r_lat;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit is_alu(input int op);
    return op >= 7 && op <= 14;
  endfunction

  function automatic int sgn(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Reference model: integer arithmetic on the architectural state
  task automatic model_apply(input int op, input int imm);
    int r, c, v, s;
    r = 0; c = 0; v = 0;
    case (op)
      0: r = imm;
      1: r = 0;
      14: r = m_acc & imm;
      13: r = m_acc | imm;
      12: r = 255 - m_acc;
      11: r = m_acc ^ imm;
      10: begin
        r = (m_acc + imm) % 256; c = (m_acc + imm) > 255;
        s = sgn(m_acc) + sgn(imm); v = (s > 127 || s < -128);
      end
      9: begin
        r = (m_acc - imm + 256) % 256; c = m_acc < imm;
        s = sgn(m_acc) - sgn(imm); v = (s > 127 || s < -128);
      end
      8: r = imm;
      7: r = (m_acc == 0) ? 1 : 0;
      default: begin m_err = 1; return; end
    endcase
`ifdef ALU_SEQ_SAT_EN
    if (op == 10 && c == 1) r = 255;
    if (op == 9 && c == 1) r = 0;
`endif
    m_acc = r; m_z = (r == 0); m_c = c; m_v = v; m_err = 0;
  endtask

  task automatic model_reset();
    m_acc = 0; m_z = 0; m_c = 0; m_v = 0; m_err = 0;
  endtask

  // Issue one instruction; returns with out_valid sampled high (or timed out)
  task automatic run_op(input logic [3:0] op, input logic [7:0] imm);
    @(negedge clk);
    chk("in_ready_idle", int'(in_ready), 1);
    in_valid = 1'b1; in_op = op; in_imm = imm;
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = 4'($urandom); in_imm = 8'($urandom);
    r_lat = 1;
    while (!out_valid && r_lat < 64) begin
      @(posedge clk); #1;
      r_lat++;
    end
    chk("out_valid_rise", int'(out_valid), 1);
  endtask

  task automatic release_resp(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("resp_hold", int'(out_valid), 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic expect_res(input string tag, input int op, input int imm, input int a, input int z,
                            input int c, input int v, input int e);
    chk({tag, "_acc"}, int'(acc), a);
    chk({tag, "_z"}, int'(flag_z), z);
    chk({tag, "_c"}, int'(flag_c), c);
    chk({tag, "_v"}, int'(flag_v), v);
    chk({tag, "_err"}, int'(out_err), e);
    chk({tag, "_lat"}, r_lat, is_alu(op) ? SETTLE + 2 : 1);
    if (is_alu(op)) begin
      chk({tag, "_alu_s"}, int'(alu_s), op);
      chk({tag, "_alu_b"}, int'(alu_b), imm);
    end
  endtask

  typedef struct {
    logic [3:0] op; logic [7:0] imm; logic [7:0] acc;
    logic z, c, v, err;
  } vec_t;
  vec_t tbl[18];

  task automatic setv(input int i, input logic [3:0] op, input logic [7:0] imm, input logic [7:0] a,
                      input logic z, input logic c, input logic v, input logic e);
    tbl[i].op = op; tbl[i].imm = imm; tbl[i].acc = a;
    tbl[i].z = z; tbl[i].c = c; tbl[i].v = v; tbl[i].err = e;
  endtask

  initial begin
    setv(0,  4'h0, 8'hC8, 8'hC8, 0, 0, 0, 0);
`ifdef ALU_SEQ_SAT_EN
    setv(1,  4'hA, 8'h64, 8'hFF, 0, 1, 0, 0);
`else
    setv(1,  4'hA, 8'h64, 8'h2C, 0, 1, 0, 0);
`endif
    setv(2,  4'h0, 8'h01, 8'h01, 0, 0, 0, 0);
    setv(3,  4'h9, 8'h01, 8'h00, 1, 0, 0, 0);
    setv(4,  4'hC, 8'h00, 8'hFF, 0, 0, 0, 0);
    setv(5,  4'h1, 8'h3C, 8'h00, 1, 0, 0, 0);
    setv(6,  4'h7, 8'h00, 8'h01, 0, 0, 0, 0);
    setv(7,  4'h0, 8'hFF, 8'hFF, 0, 0, 0, 0);
    setv(8,  4'h7, 8'h00, 8'h00, 1, 0, 0, 0);
    setv(9,  4'h0, 8'h55, 8'h55, 0, 0, 0, 0);
    setv(10, 4'h4, 8'h12, 8'h55, 0, 0, 0, 1);
    setv(11, 4'hE, 8'h0F, 8'h05, 0, 0, 0, 0);
    setv(12, 4'hB, 8'h05, 8'h00, 1, 0, 0, 0);
    setv(13, 4'hD, 8'hA0, 8'hA0, 0, 0, 0, 0);
`ifdef ALU_SEQ_SAT_EN
    setv(14, 4'h9, 8'hA1, 8'h00, 1, 1, 0, 0);
    setv(15, 4'hF, 8'h77, 8'h00, 1, 1, 0, 1);
`else
    setv(14, 4'h9, 8'hA1, 8'hFF, 0, 1, 0, 0);
    setv(15, 4'hF, 8'h77, 8'hFF, 0, 1, 0, 1);
`endif
    setv(16, 4'h0, 8'h7F, 8'h7F, 0, 0, 0, 0);
    setv(17, 4'hA, 8'h01, 8'h80, 0, 0, 1, 0);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_op = '0; in_imm = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acc", int'(acc), 0);
    chk("rst_flags", int'({flag_z, flag_c, flag_v, out_err}), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_alu_s", int'(alu_s), 8);
    chk("rst_alu_ab", int'({alu_a, alu_b}), 0);
    rst = 1'b0;
    model_reset();

    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].imm);
      expect_res($sformatf("vec%0d", i), int'(tbl[i].op), int'(tbl[i].imm), int'(tbl[i].acc),
                 int'(tbl[i].z), int'(tbl[i].c), int'(tbl[i].v), int'(tbl[i].err));
      model_apply(int'(tbl[i].op), int'(tbl[i].imm));
      release_resp(i % 3);
    end

    // Backpressure: RESP held, stray in_valid ignored
    run_op(4'h0, 8'h10); model_apply(0, 16); release_resp(0);
    run_op(4'hA, 8'h20); model_apply(10, 32);
    in_valid = 1'b1; in_op = 4'h0; in_imm = 8'h99;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_acc", int'(acc), 8'h30);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_in_ready", int'(in_ready), 1);
    chk("bp_release_out_valid", int'(out_valid), 0);
    chk("bp_release_acc", int'(acc), 8'h30);

    // Reset while the op sits in ISSUE
    run_op(4'h0, 8'h33); model_apply(0, 8'h33); release_resp(0);
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'hA; in_imm = 8'h07;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("mid_rst_acc", int'(acc), 0);
    chk("mid_rst_flags", int'({flag_z, flag_c, flag_v, out_err}), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    repeat (SETTLE + 2) begin
      @(posedge clk); #1;
      chk("mid_rst_no_resp", int'(out_valid), 0);
    end
    run_op(4'hA, 8'h05); model_apply(10, 5);
    chk("post_rst_add", int'(acc), 5);
    release_resp(0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 200; n++) begin
      logic [3:0] op;
      logic [7:0] imm;
      op = 4'($urandom_range(0, 15));
      imm = 8'($urandom);
      if (n % 8 == 0) op = 4'h0;
      run_op(op, imm);
      model_apply(int'(op), int'(imm));
      expect_res("rnd", int'(op), int'(imm), m_acc, m_z, m_c, m_v, m_err);
      release_resp(int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Sequential front-end that feeds the 8-bit combinational ALU (ports a, b, s in; r, c, v out).
- Accepts op/immediate instructions over a valid/ready handshake and drives the ALU with the accumulator and immediate.
- Captures r/c/v into an accumulator and flag register, then returns the result over a second valid/ready handshake.
- Sits between the instruction source and the ALU, one transaction in flight at a time.

Parameters:
- W, 8, datapath width; must match the ALU width.
- SETTLE, 1, cycles the ALU inputs are held stable before capture (1..4).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  instruction valid
- in_ready  output  1  block can accept an instruction
- in_op  input  4  opcode
- in_imm  input  W  immediate operand
- alu_a  output  W  to ALU a (accumulator snapshot)
- alu_b  output  W  to ALU b (immediate)
- alu_s  output  4  to ALU s
- alu_r  input  W  from ALU r
- alu_c  input  1  from ALU c
- alu_v  input  1  from ALU v
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- acc  output  W  accumulator value
- flag_z  output  1  result == 0
- flag_c  output  1  carry from last ALU op
- flag_v  output  1  overflow from last ALU op
- out_err  output  1  last op was illegal

Behaviour:
- Reset values: acc=0, flags=0, out_err=0, out_valid=0, alu_a/alu_b=0, alu_s=4'b1000 (transfer), state=IDLE, in_ready=1.
- Opcodes:
  - ALU ops pass straight through to alu_s: 1110 and, 1101 or, 1100 not, 1011 xor, 1010 add, 1001 sub, 1000 transfer, 0111 test.
  - Local ops: 0000 LOAD (acc<=imm), 0001 CLEAR (acc<=0).
  - 0010-0110 and 1111 are illegal.
- State machine:
  - IDLE: in_ready=1. On in_valid&in_ready, register alu_a<=acc, alu_b<=imm, alu_s<=op (ALU ops); set settle counter=SETTLE-1; go to ISSUE. LOAD/CLEAR/illegal go directly to RESP.
  - ISSUE: in_ready=0; alu_a/b/s held constant. When counter=0, go to CAPTURE, else decrement.
  - CAPTURE: sample acc<=alu_r, flag_c<=alu_c, flag_v<=alu_v, flag_z<=(alu_r==0), out_err<=0; go to RESP.
  - RESP: out_valid=1. Hold acc/flags until out_valid&out_ready, then return to IDLE.
- Latency: out_valid rises SETTLE+2 cycles after the accept edge for ALU ops, and 1 cycle for local/illegal ops.
- LOAD/CLEAR update acc; flag_z from the new acc; c=v=0; out_err=0.
- Illegal op: acc and flags unchanged, out_err=1; still responds through RESP.
- in_ready is 0 in ISSUE, CAPTURE and RESP; in_valid is ignored there. No accept in the same cycle as the RESP handshake; the next accept is earliest in the following IDLE cycle.
- out_ready held low keeps RESP indefinitely with outputs stable.
- rst asserted in any state: all outputs take their reset values on that edge and any in-flight op is discarded.
- Width rule: acc is exactly W bits. Carry/overflow come only from the ALU and are never recomputed locally.

Optional Feature:
- Macro ALU_SEQ_SAT_EN.
- When defined: in CAPTURE, for add (1010) with alu_c=1, acc<={W{1}}. For sub (1001) with alu_c=1 (borrow), acc<=0. flag_c/flag_v are still recorded from the ALU, and flag_z follows the saturated acc.
- When undefined: acc<=alu_r unconditionally, i.e. wrap-around.

Test Plan:
- Reset, then LOAD imm=200, then add imm=100 → after the handshake acc=8'h2C, flag_c=1, flag_v=0, flag_z=0. With ALU_SEQ_SAT_EN: acc=8'hFF, flag_c=1.
- LOAD 1, then sub 1 → acc=0, flag_z=1, flag_c=0, flag_v=0. Then not (1100) imm=0 → acc=8'hFF, flag_z=0.
- CLEAR, then test (0111) → acc=1. LOAD 255, then test → acc=0, flag_z=1.
- Opcode 0100 with acc=8'h55 → out_err=1, acc=8'h55 unchanged, out_valid asserted 1 cycle after accept.
- Add issued with out_ready held low for 10 cycles → out_valid stays 1, acc stable, in_ready=0, extra in_valid ignored. Raise out_ready → in_ready=1 on the next cycle.
- rst pulsed during ISSUE → next cycle acc=0, all flags 0, out_valid=0, in_ready=1; the subsequent add uses acc=0.
